// File: rtl/uart_baud_gen_frac.sv
// Fractional-N UART baud generator: rx tick at OVERSAMPLE x baud, tx tick every
// OVERSAMPLE rx ticks, both from one counter chain so they stay phase-locked.
module uart_baud_gen_frac #(
   parameter int unsigned CLK_HZ       = 50_000_000,
   parameter int unsigned BAUD_DEFAULT = 115200,
   parameter int unsigned OVERSAMPLE   = 16,
   parameter int unsigned INT_W        = 16,
   parameter int unsigned FRAC_W       = 4
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic              en,
   input  logic              div_wr,
   input  logic [INT_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              rx_resync,
   output logic              rxclk_en,
   output logic              txclk_en,
   output logic [INT_W-1:0]  div_int_q,
   output logic [FRAC_W-1:0] div_frac_q
);

   localparam longint unsigned DIV_RESET =
      (longint'(CLK_HZ) * (longint'(1) << FRAC_W)) / (longint'(BAUD_DEFAULT) * longint'(OVERSAMPLE));
   localparam int unsigned OS_W = $clog2(OVERSAMPLE);
   localparam logic [INT_W-1:0]  RST_INT  = INT_W'(DIV_RESET >> FRAC_W);
   localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DIV_RESET);

   // Periods below 2 cycles would let cnt underflow on reload.
   function automatic logic [INT_W-1:0] clamp_int(input logic [INT_W-1:0] v);
      return (v < INT_W'(2)) ? INT_W'(2) : v;
   endfunction

   logic [INT_W-1:0]  cnt;
   logic [OS_W-1:0]   os_cnt;
   logic [FRAC_W-1:0] facc;
   logic              pending;
   logic [INT_W-1:0]  shadow_int;
   logic [FRAC_W-1:0] shadow_frac;
   logic [INT_W-1:0]  active_int;
   logic [FRAC_W-1:0] active_frac;

   logic [INT_W-1:0]  int_sel;
   logic [FRAC_W-1:0] frac_sel;
   logic [FRAC_W:0]   facc_sum;
   logic [INT_W-1:0]  cnt_reload;

   always_comb begin
      int_sel  = active_int;
      frac_sel = active_frac;
      if (div_wr) begin
         int_sel  = clamp_int(div_int);
         frac_sel = div_frac;
      end else if (pending) begin
         int_sel  = shadow_int;
         frac_sel = shadow_frac;
      end
      facc_sum   = {1'b0, facc} + {1'b0, frac_sel};
      cnt_reload = int_sel - INT_W'(1) + INT_W'(facc_sum[FRAC_W]);
   end

   assign rxclk_en   = rst_n & en & (cnt == '0);
   assign txclk_en   = rxclk_en & (os_cnt == '0);
   assign div_int_q  = active_int;
   assign div_frac_q = active_frac;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         os_cnt      <= '0;
         facc        <= '0;
         pending     <= 1'b0;
         shadow_int  <= RST_INT;
         shadow_frac <= RST_FRAC;
         active_int  <= RST_INT;
         active_frac <= RST_FRAC;
      end else if (rx_resync) begin
         cnt         <= '0;
         os_cnt      <= '0;
         facc        <= '0;
         active_int  <= int_sel;
         active_frac <= frac_sel;
         pending     <= 1'b0;
      end else if (rxclk_en) begin
         // Fraction accumulator carry stretches this period by one cycle.
         facc        <= facc_sum[FRAC_W-1:0];
         cnt         <= cnt_reload;
         os_cnt      <= os_cnt + OS_W'(1);
         active_int  <= int_sel;
         active_frac <= frac_sel;
         pending     <= 1'b0;
      end else begin
         if (en) begin
            cnt <= cnt - INT_W'(1);
         end
         if (div_wr) begin
            shadow_int  <= clamp_int(div_int);
            shadow_frac <= div_frac;
            pending     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Scoreboard bench for uart_baud_gen_frac: expected tick intervals are queued as
// stimulus is applied and compared as the DUT produces rx/tx ticks.
module tb_uart_baud_gen_frac;

   localparam int OS = 16;

   logic        clk_50m = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic        div_wr = 1'b0;
   logic [15:0] div_int = '0;
   logic [3:0]  div_frac = '0;
   logic        rx_resync = 1'b0;
   logic        rxclk_en;
   logic        txclk_en;
   logic [15:0] div_int_q;
   logic [3:0]  div_frac_q;

   int errors = 0;
   int checks = 0;
   int since_rx = 0;
   int since_tx = 0;
   int rx_since_tx = 0;
   int rx_seen = 0;
   int seen_before = 0;
   bit os_chk = 1'b0;
   int rx_q[$];
   int tx_q[$];

   always #5 clk_50m = ~clk_50m;

   uart_baud_gen_frac dut (
      .clk_50m   (clk_50m),
      .rst_n     (rst_n),
      .en        (en),
      .div_wr    (div_wr),
      .div_int   (div_int),
      .div_frac  (div_frac),
      .rx_resync (rx_resync),
      .rxclk_en  (rxclk_en),
      .txclk_en  (txclk_en),
      .div_int_q (div_int_q),
      .div_frac_q(div_frac_q)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One clock: sample at the falling edge and score any tick seen.
   task automatic step();
      @(negedge clk_50m);
      since_rx++;
      since_tx++;
      if (rxclk_en === 1'b1) begin
         rx_seen++;
         rx_since_tx++;
         if (rx_q.size() > 0) check("rx_interval", since_rx, rx_q.pop_front());
         since_rx = 0;
         if (txclk_en === 1'b1) begin
            if (tx_q.size() > 0) check("tx_interval", since_tx, tx_q.pop_front());
            if (os_chk) check("rx_per_tx", rx_since_tx, OS);
            since_tx = 0;
            rx_since_tx = 0;
         end
      end else if (txclk_en !== 1'b0) begin
         check("tx_without_rx", txclk_en, 0);
      end
   endtask

   task automatic wait_rx();
      for (int i = 0; i < 3000; i++) begin
         step();
         if (rxclk_en === 1'b1) return;
      end
      check("rx_timeout", 0, 1);
   endtask

   task automatic wait_n(input int n);
      repeat (n) step();
   endtask

   // One tx period at the reset divisor 27 + 2/16.
   task automatic push_default();
      for (int k = 1; k <= 16; k++) rx_q.push_back((k % 8 == 0) ? 28 : 27);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk_50m);
      check("rst_rx", rxclk_en, 0);
      check("rst_tx", txclk_en, 0);
      check("rst_int", div_int_q, 27);
      check("rst_frac", div_frac_q, 2);

      // Test 1: defaults from reset release
      rst_n = 1'b1;
      #1;
      check("t1_rx0", rxclk_en, 1);
      check("t1_tx0", txclk_en, 1);
      since_rx = 0; since_tx = 0; rx_since_tx = 0; os_chk = 1'b1;
      push_default();
      push_default();
      tx_q.push_back(434);
      tx_q.push_back(434);
      repeat (32) wait_rx();
      check("t1_all_seen", rx_q.size() + tx_q.size(), 0);

      // Test 2: mid-period write takes effect at the next boundary
      wait_n(5);
      div_wr = 1'b1; div_int = 16'd10; div_frac = 4'd0;
      rx_q.push_back(27);
      repeat (4) rx_q.push_back(10);
      step();
      div_wr = 1'b0;
      check("t2_hold_int", div_int_q, 27);
      wait_rx();
      check("t2_hold_at_tick", div_int_q, 27);
      step();
      check("t2_new_int", div_int_q, 10);
      repeat (4) wait_rx();

      // Test 3: clamp of int=0 and int=1
      div_wr = 1'b1; div_int = 16'd0; div_frac = 4'd0;
      repeat (60) rx_q.push_back(2);
      step();
      check("t3_clamp0", div_int_q, 2);
      div_int = 16'd1;
      step();
      div_wr = 1'b0;
      step();
      check("t3_clamp1", div_int_q, 2);
      check("t3_frac", div_frac_q, 0);
      for (int i = 0; i < 20; i++) begin
         wait_rx();
         if (txclk_en === 1'b1) break;
      end
      tx_q.push_back(32);
      tx_q.push_back(32);
      repeat (32) wait_rx();
      check("t3_tx_seen", tx_q.size(), 0);
      rx_q.delete();

      // Test 4: en low for 50 cycles mid-interval, int=5 frac=8
      div_wr = 1'b1; div_int = 16'd5; div_frac = 4'd8;
      rx_q.push_back(5); rx_q.push_back(6); rx_q.push_back(5); rx_q.push_back(6);
      rx_q.push_back(55); rx_q.push_back(6); rx_q.push_back(5);
      step();
      div_wr = 1'b0;
      repeat (4) wait_rx();
      wait_n(2);
      en = 1'b0;
      seen_before = rx_seen;
      wait_n(50);
      check("t4_no_ticks", rx_seen - seen_before, 0);
      en = 1'b1;
      repeat (3) wait_rx();
      check("t4_all_seen", rx_q.size(), 0);

      // Test 5: resync with same-cycle write
      wait_n(2);
      os_chk = 1'b0;
      rx_q.delete();
      tx_q.delete();
      rx_resync = 1'b1; div_wr = 1'b1; div_int = 16'd20; div_frac = 4'd0;
      step();
      rx_resync = 1'b0; div_wr = 1'b0;
      check("t5_rx", rxclk_en, 1);
      check("t5_tx", txclk_en, 1);
      check("t5_int", div_int_q, 20);
      repeat (3) rx_q.push_back(20);
      repeat (3) wait_rx();
      os_chk = 1'b1;

      // Test 6: reset pulse with a pending write
      wait_n(3);
      div_wr = 1'b1; div_int = 16'd9; div_frac = 4'd1;
      step();
      div_wr = 1'b0;
      check("t6_pending", div_int_q, 20);
      rst_n = 1'b0;
      #1;
      check("t6_rst_rx", rxclk_en, 0);
      check("t6_rst_int", div_int_q, 27);
      check("t6_rst_frac", div_frac_q, 2);
      @(negedge clk_50m);
      check("t6_rst_hold_rx", rxclk_en, 0);
      rst_n = 1'b1;
      #1;
      check("t6_rx0", rxclk_en, 1);
      check("t6_tx0", txclk_en, 1);
      since_rx = 0; since_tx = 0; rx_since_tx = 0;
      rx_q.delete();
      tx_q.delete();
      push_default();
      tx_q.push_back(434);
      repeat (16) wait_rx();
      check("t6_int_after", div_int_q, 27);
      check("t6_frac_after", div_frac_q, 2);
      check("t6_all_seen", rx_q.size() + tx_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
